// File: rtl/input_conditioner_array.sv
// input_conditioner_array: N-channel sync/invert/debounce/press/release/held front end; INPUT_COND_AUTOREPEAT_EN adds press auto-repeat
module input_conditioner_array #(
  parameter int N_CH = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC = 250_000_000,
  parameter logic [N_CH-1:0] INV_MASK = '0,
  parameter int REPEAT_CYC = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] held_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
  logic [N_CH-1:0] sync1, sync2, s;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= INV_MASK;
      sync2 <= INV_MASK;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end
  assign s = sync2 ^ INV_MASK;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DW-1:0] cnt;
    logic [HW-1:0] hold_cnt;
    logic stable, stable_n, acc, rep, press_r, rel_r, hp_r;
    state_t state, state_n;
    assign acc = (s[g] != stable) && (cnt == DW'(DEBOUNCE_CYC - 1));
    assign stable_n = acc ? s[g] : stable;
    always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (stable_n ? PRESS : IDLE) :
                !stable_n ? IDLE :
                (state == PRESS && hold_cnt == HW'(HOLD_CYC - 1)) ? HELD : state;
    end
`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC + 1);
    logic [RW-1:0] rep_cnt;
    assign rep = (state == HELD) && (state_n == HELD) && (rep_cnt == RW'(REPEAT_CYC - 1));
    always_ff @(posedge clk) begin
      if (rst)
        rep_cnt <= '0;
      else
        rep_cnt <= (state == HELD && state_n == HELD && !rep) ? rep_cnt + RW'(1) : '0;
    end
`else
    assign rep = 1'b0;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        stable <= 1'b0;
        state <= IDLE;
        hold_cnt <= '0;
        press_r <= 1'b0;
        rel_r <= 1'b0;
        hp_r <= 1'b0;
      end else begin
        cnt <= (s[g] == stable || acc) ? '0 : cnt + DW'(1);
        stable <= stable_n;
        state <= state_n;
        hold_cnt <= (state == PRESS && state_n == PRESS) ? hold_cnt + HW'(1) : '0;
        press_r <= (stable_n & ~stable) | rep;
        rel_r <= ~stable_n & stable;
        hp_r <= (state_n == HELD) && (state != HELD);
      end
    end
    assign level[g] = stable;
    assign press[g] = press_r;
    assign release_pulse[g] = rel_r;
    assign held[g] = state == HELD;
    assign held_pulse[g] = hp_r;
  end
endmodule

// File: tb/tb_input_conditioner_array.sv
// tb_input_conditioner_array: randomized and directed checks against a history-based reference model
module tb_input_conditioner_array;
  localparam int DEB = 4;
  localparam int HOLD = 20;
  localparam int REP = 8;
  localparam logic [3:0] INV = 4'b0011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] raw_in = INV;
  logic [3:0] level, press, release_pulse, held, held_pulse;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] m_q1, m_q2, m_stable, m_press, m_rel, m_held, m_hp;
  int m_t[4];
  bit hist[4][$];
  input_conditioner_array #(
    .N_CH(4), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .INV_MASK(INV), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .level(level), .press(press),
    .release_pulse(release_pulse), .held(held), .held_pulse(held_pulse)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input logic r, input logic [3:0] d);
    logic [3:0] s_now;
    bit prev, all_diff, h;
    if (r) begin
      {m_q1, m_q2, m_stable, m_press, m_rel, m_held, m_hp} = '0;
      for (int c = 0; c < 4; c++) begin
        hist[c].delete();
        m_t[c] = 0;
      end
    end else begin
      s_now = m_q2;
      m_q2 = m_q1;
      m_q1 = d ^ INV;
      for (int c = 0; c < 4; c++) begin
        hist[c].push_back(s_now[c]);
        if (hist[c].size() > DEB) void'(hist[c].pop_front());
        prev = m_stable[c];
        all_diff = hist[c].size() == DEB;
        foreach (hist[c][k]) if (hist[c][k] == prev) all_diff = 0;
        if (all_diff) m_stable[c] = s_now[c];
        m_press[c] = !prev && m_stable[c];
        m_rel[c] = prev && !m_stable[c];
        if (m_press[c]) m_t[c] = 0;
        else if (m_stable[c] && m_t[c] < 100000) m_t[c]++;
        h = m_stable[c] && m_t[c] >= HOLD;
        m_hp[c] = h && !m_held[c];
        m_held[c] = h;
`ifdef INPUT_COND_AUTOREPEAT_EN
        if (h && m_t[c] > HOLD && (m_t[c] - HOLD) % REP == 0) m_press[c] = 1'b1;
`endif
      end
    end
  endtask
  task automatic step(input logic r, input logic [3:0] d);
    @(negedge clk);
    rst = r;
    raw_in = d;
    @(posedge clk);
    model(r, d);
    #1;
    check("level", 32'(level), 32'(m_stable));
    check("press", 32'(press), 32'(m_press));
    check("release", 32'(release_pulse), 32'(m_rel));
    check("held", 32'(held), 32'(m_held));
    check("held_pulse", 32'(held_pulse), 32'(m_hp));
  endtask
  initial begin
    int pc, cnt_p, cnt_h;
    int rem[4];
    logic [3:0] cur;
    repeat (3) step(1'b1, 4'b0011);
    check("rst_outputs", 32'({level, press, release_pulse, held, held_pulse}), 32'd0);
    repeat (8) step(1'b0, 4'b0011);
    check("idle_level", 32'(level), 32'd0);
    pc = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 4'b0111);
      if (press[2]) pc = i;
    end
    check("t2_press_lat", 32'(pc), 32'd6);
    check("t2_others", 32'(level & 4'b1011), 32'd0);
    repeat (10) step(1'b0, 4'b0011);
    cnt_p = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, (i < 8 && (i / 2) % 2 == 1) ? 4'b0011 : 4'b0111);
      cnt_p += int'(press[2]);
    end
    check("t3_one_press", 32'(cnt_p), 32'd1);
    repeat (10) step(1'b0, 4'b0011);
    cnt_h = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'b0010);
      cnt_h += int'(held_pulse[0]);
    end
    check("t4_held_pulse", 32'(cnt_h), 32'd1);
    step(1'b0, 4'b0011);
    repeat (6) begin
      step(1'b0, 4'b0011);
      if (release_pulse[0]) check("t4_held_clr", 32'(held[0]), 32'd0);
    end
    cnt_h = 0;
    cnt_p = 0;
    for (int i = 0; i < 22; i++) begin
      step(1'b0, i < 10 ? 4'b1111 : 4'b0011);
      cnt_h += int'(held[3] | held[2]);
      if (press[3] && press[2]) cnt_p++;
    end
    check("t5_joint_press", 32'(cnt_p), 32'd1);
    check("t5_no_held", 32'(cnt_h), 32'd0);
    repeat (10) step(1'b0, 4'b0111);
    check("t6_level_pre", 32'(level[2]), 32'd1);
    step(1'b1, 4'b0111);
    check("t6_rst_out", 32'({level, press, release_pulse, held, held_pulse}), 32'd0);
    pc = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 4'b0111);
      if (press[2] && pc == 0) pc = i;
    end
    check("t6_repress", 32'(pc), 32'd6);
    cnt_p = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 4'b1011);
      cnt_p += int'(press[3]);
    end
`ifdef INPUT_COND_AUTOREPEAT_EN
    check("t7_repeats", 32'(cnt_p), 32'd5);
`else
    check("t7_no_repeat", 32'(cnt_p), 32'd1);
`endif
    cur = 4'b0011;
    rem = '{0, 0, 0, 0};
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom % 4 == 0) ? $urandom_range(20, 40) : $urandom_range(1, 6);
        end
        rem[c]--;
      end
      step($urandom_range(0, 399) == 0, cur);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
